// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, LOCK} arb_state_e;

  localparam int DEF_DSIZE    = 8;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAXBURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          found = 1'b1;
          idx   = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter multiplexing NREQ write streams onto one FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE    = DEF_DSIZE,
  parameter int NREQ     = DEF_NREQ,
  parameter int MAXBURST = DEF_MAXBURST
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    win,
  output logic [DSIZE-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [15:0]             beat_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST);
  localparam logic [BW-1:0] BLAST = BW'(MAXBURST - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_q, rr_d, pick_idx;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [15:0]   beat_q;
  logic          pick_found, own_vld, own_last, xfer;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner mux; wdata follows grant_q even in IDLE so reset shows requester 0.
  always_comb begin
    own_vld   = 1'b0;
    own_last  = 1'b0;
    wdata     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IW'(i)) begin
        own_vld      = req_valid[i];
        own_last     = req_last[i];
        wdata        = req_data[i*DSIZE +: DSIZE];
        req_ready[i] = (state_q == LOCK) && !wfull;
      end
    end
  end

  assign xfer = (state_q == LOCK) && own_vld && !wfull;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          bcnt_d  = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          bcnt_d = bcnt_q + 1'b1;
          if (own_last || (bcnt_q == BLAST)) begin
            state_d = IDLE;
            rr_d    = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      bcnt_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      bcnt_q  <= bcnt_d;
      if (xfer) beat_q <= beat_q + 16'd1;
    end
  end

  assign win      = xfer;
  assign grant_id = grant_q;
  assign busy     = (state_q == LOCK);
  assign beat_cnt = beat_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus burst, stall and reset sequences.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        wfull, win, busy;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic [15:0] beat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .MAXBURST(4)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .win       (win),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  v;
    logic [3:0]  l;
    logic        wf;
    int          seq;
    logic        e_win;
    logic [3:0]  e_rdy;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic [7:0]  e_wdata;
    logic [15:0] e_beat;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic [3:0] v, l, input logic wf,
                              input int seq, input logic e_win, input logic [3:0] e_rdy,
                              input logic [1:0] e_gid, input logic e_busy,
                              input logic [7:0] e_wdata, input logic [15:0] e_beat);
    mk = '{rst_n, v, l, wf, seq, e_win, e_rdy, e_gid, e_busy, e_wdata, e_beat};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester i presents byte {i, seq}.
  task automatic drive(input logic [3:0] v, l, input logic wf, input int seq);
    req_valid = v;
    req_last  = l;
    wfull     = wf;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {4'(i), 4'(seq)};
  endtask

  task automatic reset_dut();
    @(negedge wclk);
    wrst_n = 1'b0;
    drive(4'h0, 4'h0, 1'b0, 0);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  vec_t tbl[18];
  int   n, cur, nb, gap, stall;
  logic prev_busy, wf;
  int   lens[4], gaps[4];

  initial begin
    wrst_n = 1'b0;
    drive(4'h0, 4'h0, 1'b0, 0);

    // Single 3-word packet from requester 2, then all four contending with 1-beat packets.
    tbl[0]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0);
    tbl[1]  = mk(1, 4'h4, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0);
    tbl[2]  = mk(1, 4'h4, 4'h0, 0, 0, 1, 4'h4, 2, 1, 8'h20, 0);
    tbl[3]  = mk(1, 4'h4, 4'h0, 0, 1, 1, 4'h4, 2, 1, 8'h21, 1);
    tbl[4]  = mk(1, 4'h4, 4'h4, 0, 2, 1, 4'h4, 2, 1, 8'h22, 2);
    tbl[5]  = mk(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 2, 0, 8'h20, 3);
    tbl[6]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0);
    tbl[7]  = mk(1, 4'hF, 4'hF, 0, 5, 0, 4'h0, 0, 0, 8'h05, 0);
    tbl[8]  = mk(1, 4'hF, 4'hF, 0, 5, 1, 4'h1, 0, 1, 8'h05, 0);
    tbl[9]  = mk(1, 4'hF, 4'hF, 0, 5, 0, 4'h0, 0, 0, 8'h05, 1);
    tbl[10] = mk(1, 4'hF, 4'hF, 0, 5, 1, 4'h2, 1, 1, 8'h15, 1);
    tbl[11] = mk(1, 4'hF, 4'hF, 0, 5, 0, 4'h0, 1, 0, 8'h15, 2);
    tbl[12] = mk(1, 4'hF, 4'hF, 0, 5, 1, 4'h4, 2, 1, 8'h25, 2);
    tbl[13] = mk(1, 4'hF, 4'hF, 0, 5, 0, 4'h0, 2, 0, 8'h25, 3);
    tbl[14] = mk(1, 4'hF, 4'hF, 0, 5, 1, 4'h8, 3, 1, 8'h35, 3);
    tbl[15] = mk(1, 4'hF, 4'hF, 0, 5, 0, 4'h0, 3, 0, 8'h35, 4);
    tbl[16] = mk(1, 4'hF, 4'hF, 0, 5, 1, 4'h1, 0, 1, 8'h05, 4);
    tbl[17] = mk(1, 4'h0, 4'h0, 0, 5, 0, 4'h0, 0, 0, 8'h05, 5);

    for (int r = 0; r < 18; r++) begin
      @(negedge wclk);
      wrst_n = tbl[r].rst_n;
      drive(tbl[r].v, tbl[r].l, tbl[r].wf, tbl[r].seq);
      #1;
      chk($sformatf("vec%0d win", r),   32'(win),       32'(tbl[r].e_win));
      chk($sformatf("vec%0d ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("vec%0d gid", r),   32'(grant_id),  32'(tbl[r].e_gid));
      chk($sformatf("vec%0d busy", r),  32'(busy),      32'(tbl[r].e_busy));
      chk($sformatf("vec%0d wdata", r), 32'(wdata),     32'(tbl[r].e_wdata));
      chk($sformatf("vec%0d beat", r),  32'(beat_cnt),  32'(tbl[r].e_beat));
    end

    // Requester 1 streams 10 words, last on the 10th: bursts of 4,4,2 with one idle cycle between.
    reset_dut();
    n = 0; cur = 0; nb = 0; gap = 0; prev_busy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge wclk);
      drive((n < 10) ? 4'h2 : 4'h0, (n == 9) ? 4'h2 : 4'h0, 1'b0, n);
      #1;
      if (win) begin
        chk("burst wdata", 32'(wdata), 32'({4'h1, 4'(n)}));
        chk("burst gid", 32'(grant_id), 32'd1);
        cur++;
        n++;
      end
      if (busy) begin
        if (!prev_busy && nb < 4) gaps[nb] = gap;
      end else begin
        if (prev_busy) begin
          if (nb < 4) lens[nb] = cur;
          nb++;
          cur = 0;
          gap = 0;
        end
        gap++;
      end
      prev_busy = busy;
    end
    chk("burst count", 32'(nb), 32'd3);
    chk("burst0 len", 32'(lens[0]), 32'd4);
    chk("burst1 len", 32'(lens[1]), 32'd4);
    chk("burst2 len", 32'(lens[2]), 32'd2);
    chk("burst0 gap", 32'(gaps[0]), 32'd1);
    chk("burst1 gap", 32'(gaps[1]), 32'd1);
    chk("burst2 gap", 32'(gaps[2]), 32'd1);
    chk("burst beats", 32'(beat_cnt), 32'd10);

    // Requester 0 sends 4 words; wfull held 5 cycles after beat 2.
    reset_dut();
    n = 0; stall = 5;
    for (int c = 0; c < 30; c++) begin
      @(negedge wclk);
      wf = (n == 2) && (stall > 0);
      drive((n < 4) ? 4'h1 : 4'h0, (n == 3) ? 4'h1 : 4'h0, wf, n);
      #1;
      if (wf) begin
        chk("stall win", 32'(win), 32'd0);
        chk("stall ready", 32'(req_ready), 32'd0);
        chk("stall busy", 32'(busy), 32'd1);
        stall--;
      end
      if (win) begin
        chk("stall wdata", 32'(wdata), 32'({4'h0, 4'(n)}));
        n++;
      end
    end
    chk("stall beats seen", 32'(n), 32'd4);
    chk("stall cycles", 32'(stall), 32'd0);
    chk("stall beat_cnt", 32'(beat_cnt), 32'd4);
    chk("stall released", 32'(busy), 32'd0);

    // Reset during beat 2 of requester 3; first grant afterwards goes to 0.
    reset_dut();
    drive(4'h8, 4'h0, 1'b0, 0);
    #1 chk("rst idle", 32'(busy), 32'd0);
    @(negedge wclk);
    drive(4'h8, 4'h0, 1'b0, 0);
    #1;
    chk("rst beat1 win", 32'(win), 32'd1);
    chk("rst beat1 gid", 32'(grant_id), 32'd3);
    @(negedge wclk);
    drive(4'h8, 4'h0, 1'b0, 1);
    #1;
    chk("rst beat2 wdata", 32'(wdata), 32'h31);
    wrst_n = 1'b0;
    #1;
    chk("rst win", 32'(win), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst gid", 32'(grant_id), 32'd0);
    chk("rst beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst wdata", 32'(wdata), 32'h01);
    @(negedge wclk);
    wrst_n = 1'b1;
    drive(4'h9, 4'h0, 1'b0, 2);
    #1 chk("post-rst idle", 32'(busy), 32'd0);
    @(negedge wclk);
    #1;
    chk("post-rst busy", 32'(busy), 32'd1);
    chk("post-rst gid", 32'(grant_id), 32'd0);
    chk("post-rst ready", 32'(req_ready), 32'h1);
    chk("post-rst wdata", 32'(wdata), 32'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DSIZE, default 8, width of one FIFO write word.
REQ-002 Parameter NREQ, default 4, number of write requesters sharing the FIFO write port (range 2..8).
REQ-003 Parameter MAXBURST, default 4, maximum beats per grant (power of two, 2..16).
REQ-004 wclk  input  1  write-domain clock; all logic SHALL be on its rising edge.
REQ-005 wrst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NREQ  per-requester word-valid.
REQ-007 req_data  input  NREQ*DSIZE  per-requester word; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-008 req_last  input  NREQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-009 req_ready  output  NREQ  per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 wfull  input  1  FIFO full flag, write domain.
REQ-011 win  output  1  FIFO write enable.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 grant_id  output  clog2(NREQ)  current/last owner index, registered.
REQ-014 busy  output  1  high while a grant is held.
REQ-015 beat_cnt  output  16  total beats written, wrapping.

Function
REQ-016 FSM states SHALL be IDLE and LOCK.
REQ-017 In IDLE, req_ready=0 and win=0; if any req_valid is high, the block SHALL select the owner round-robin, starting from index rr_ptr, register it into grant_id and enter LOCK on the next edge (1-cycle arbitration latency).
REQ-018 In LOCK, req_ready[grant_id] SHALL equal ~wfull, all other req_ready bits 0, win = req_valid[grant_id] & ~wfull, and wdata = req_data[grant_id] (combinational).
REQ-019 win SHALL never be high while wfull is high; while wfull is high, the grant SHALL hold with no beat counted.
REQ-020 A burst counter (clog2(MAXBURST) bits) SHALL clear on grant and increment on each transfer.
REQ-021 LOCK->IDLE SHALL occur on a transfer with req_last high, or on a transfer while the burst counter equals MAXBURST-1, whichever comes first.
REQ-022 On release, rr_ptr SHALL become grant_id+1 modulo NREQ; a requester just released SHALL be lowest priority next arbitration.
REQ-023 If the owner drops req_valid in LOCK, the grant SHALL be held (packet lock) until REQ-021 is met.
REQ-024 A requester whose req_valid rises during another's LOCK SHALL wait; no preemption.
REQ-025 beat_cnt SHALL increment by 1 per asserted win, wrapping 0xFFFF->0x0000.
REQ-026 busy SHALL equal (state==LOCK).

Reset
REQ-027 On wrst_n low, asynchronously: state=IDLE, grant_id=0, rr_ptr=0, burst counter=0, beat_cnt=0; hence win=0, req_ready=0, busy=0, wdata=req_data[0].
REQ-028 Reset asserted mid-burst SHALL abandon the burst; the first post-reset grant SHALL start from index 0.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the state enum (IDLE, LOCK) and the default parameter constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs req vector and rr_ptr; outputs found flag and index), purely combinational.

Verification
REQ-031 Single requester 2 (NREQ=4) sends 3 words, last on the 3rd, wfull=0 -> grant after 1 cycle, win high 3 consecutive cycles, wdata in order, then busy=0, beat_cnt=3.
REQ-032 All 4 requesters valid continuously with single-beat packets -> grant order 0,1,2,3,0; each grant_id is held 1 transfer.
REQ-033 Requester 1 streams 10 words without last, MAXBURST=4 -> released after 4 beats; requester 1 alone is re-granted after 1 idle cycle; 3 bursts total (4,4,2 with last on the 10th).
REQ-034 wfull driven high for 5 cycles mid-burst -> win=0 and req_ready=0 for those cycles, no beat lost or duplicated, burst resumes and completes.
REQ-035 wrst_n pulsed low during beat 2 of a burst by requester 3 -> outputs zero immediately; after release with requesters 0 and 3 valid, requester 0 is granted first.
